// File: rtl/ov7670_capture_writer.sv
// OV7670 capture front end: pairs camera bytes into RGB565 pixels and writes them to the pixel FIFO.
// Optional build macro CAPTURE_DECIM_EN enables 2:1 decimation in both axes.
module ov7670_capture_writer #(
  parameter int unsigned H_PIXELS      = 640,
  parameter int unsigned V_LINES       = 480,
  parameter int unsigned OVF_CNT_WIDTH = 16
) (
  input  logic                     clk_write,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     cam_vsync,
  input  logic                     cam_href,
  input  logic [7:0]               cam_data,
  input  logic                     fifo_full,
  output logic                     fifo_write,
  output logic [15:0]              fifo_data,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     frame_err,
  output logic                     overflow,
  output logic [OVF_CNT_WIDTH-1:0] ovf_count
);

  localparam int unsigned PIX_W  = $clog2(2 * H_PIXELS + 1);
  localparam int unsigned LINE_W = $clog2(2 * V_LINES + 1);

  typedef enum logic [1:0] {IDLE, SYNC, ACTIVE} state_t;

  state_t                   state_q, state_d;
  logic                     vsync_q, vsync_prev_q, href_q, href_prev_q;
  logic [7:0]               data_q;
  logic                     phase_q, phase_d;
  logic [7:0]               hi_q, hi_d;
  logic [PIX_W-1:0]         pix_cnt_q, pix_cnt_d;
  logic [LINE_W-1:0]        line_cnt_q, line_cnt_d;
  logic                     err_q, err_d;
  logic                     fifo_write_q, fifo_write_d;
  logic [15:0]              fifo_data_q, fifo_data_d;
  logic                     busy_q, busy_d;
  logic                     frame_done_q, frame_done_d;
  logic                     frame_err_q, frame_err_d;
  logic                     overflow_q, overflow_d;
  logic [OVF_CNT_WIDTH-1:0] ovf_count_q, ovf_count_d;

  logic              vsync_fall, vsync_rise, line_end, line_err, keep;
  logic [PIX_W-1:0]  pix_cnt_inc;
  logic [LINE_W-1:0] line_cnt_inc, line_cnt_final;

  assign vsync_fall   = vsync_prev_q & ~vsync_q;
  assign vsync_rise   = vsync_q & ~vsync_prev_q;
  // A vsync rise while href is still high closes the line in the same cycle.
  assign line_end     = href_prev_q & (~href_q | vsync_rise);
  assign pix_cnt_inc  = (pix_cnt_q == '1) ? pix_cnt_q : pix_cnt_q + PIX_W'(1);
  assign line_cnt_inc = (line_cnt_q == '1) ? line_cnt_q : line_cnt_q + LINE_W'(1);
  assign line_cnt_final = line_end ? line_cnt_inc : line_cnt_q;
  assign line_err     = line_end & ((pix_cnt_q != PIX_W'(H_PIXELS)) | phase_q);

`ifdef CAPTURE_DECIM_EN
  assign keep = ~pix_cnt_q[0] & ~line_cnt_q[0];
`else
  assign keep = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    hi_d         = hi_q;
    pix_cnt_d    = pix_cnt_q;
    line_cnt_d   = line_cnt_q;
    err_d        = err_q;
    fifo_write_d = 1'b0;
    fifo_data_d  = fifo_data_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    overflow_d   = overflow_q;
    ovf_count_d  = ovf_count_q;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d     = SYNC;
          overflow_d  = 1'b0;
          ovf_count_d = '0;
        end
      end
      SYNC: begin
        if (vsync_fall) begin
          state_d    = ACTIVE;
          pix_cnt_d  = '0;
          line_cnt_d = '0;
          err_d      = 1'b0;
          phase_d    = 1'b0;
        end
      end
      ACTIVE: begin
        if (line_end) begin
          line_cnt_d = line_cnt_inc;
          pix_cnt_d  = '0;
          phase_d    = 1'b0;
          if (line_err) err_d = 1'b1;
        end
        if (vsync_rise) begin
          frame_done_d = 1'b1;
          frame_err_d  = err_q | line_err | (line_cnt_final != LINE_W'(V_LINES));
          phase_d      = 1'b0;
          state_d      = enable ? SYNC : IDLE;
        end else if (href_q) begin
          if (!phase_q) begin
            hi_d    = data_q;
            phase_d = 1'b1;
          end else begin
            phase_d   = 1'b0;
            pix_cnt_d = pix_cnt_inc;
            if (keep) begin
              if (fifo_full) begin
                overflow_d = 1'b1;
                if (ovf_count_q != '1) ovf_count_d = ovf_count_q + OVF_CNT_WIDTH'(1);
              end else begin
                fifo_write_d = 1'b1;
                fifo_data_d  = {hi_q, data_q};
              end
            end
          end
        end else begin
          phase_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_write or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      vsync_q      <= 1'b0;
      vsync_prev_q <= 1'b0;
      href_q       <= 1'b0;
      href_prev_q  <= 1'b0;
      data_q       <= '0;
      phase_q      <= 1'b0;
      hi_q         <= '0;
      pix_cnt_q    <= '0;
      line_cnt_q   <= '0;
      err_q        <= 1'b0;
      fifo_write_q <= 1'b0;
      fifo_data_q  <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
      ovf_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= cam_vsync;
      vsync_prev_q <= vsync_q;
      href_q       <= cam_href;
      href_prev_q  <= href_q;
      data_q       <= cam_data;
      phase_q      <= phase_d;
      hi_q         <= hi_d;
      pix_cnt_q    <= pix_cnt_d;
      line_cnt_q   <= line_cnt_d;
      err_q        <= err_d;
      fifo_write_q <= fifo_write_d;
      fifo_data_q  <= fifo_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      overflow_q   <= overflow_d;
      ovf_count_q  <= ovf_count_d;
    end
  end

  assign fifo_write = fifo_write_q;
  assign fifo_data  = fifo_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;
  assign ovf_count  = ovf_count_q;

endmodule

// File: tb/tb_ov7670_capture_writer.sv
// Bench for ov7670_capture_writer: frame table plus enable/reset sequences, pixel scoreboard.
module tb_ov7670_capture_writer;
  localparam int unsigned H  = 4;
  localparam int unsigned V  = 2;
  localparam int unsigned OW = 2;
`ifdef CAPTURE_DECIM_EN
  localparam bit DECIM = 1'b1;
`else
  localparam bit DECIM = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          vs = 1'b1;
  logic          hr = 1'b0;
  logic [7:0]    d = '0;
  logic          full = 1'b0;
  logic          fifo_write;
  logic [15:0]   fifo_data;
  logic          busy, frame_done, frame_err, overflow;
  logic [OW-1:0] ovf_count;

  ov7670_capture_writer #(.H_PIXELS(H), .V_LINES(V), .OVF_CNT_WIDTH(OW)) dut (
    .clk_write(clk), .rst_n(rst_n), .enable(enable),
    .cam_vsync(vs), .cam_href(hr), .cam_data(d), .fifo_full(full),
    .fifo_write(fifo_write), .fifo_data(fifo_data), .busy(busy),
    .frame_done(frame_done), .frame_err(frame_err),
    .overflow(overflow), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  typedef struct {
    string       name;
    int          l0;
    int          l1;
    int          nl;
    logic [15:0] mask;
    bit          err;
    int          ovf;
    int          ovf_dec;
  } vec_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  bit          last_err = 1'b0;
  bit          model_on = 1'b1;
  bit          have_last = 1'b0;
  bit          pend_full = 1'b0;
  logic [15:0] last_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Output monitor: scoreboard pops on every strobe, frame status captured.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (fifo_write) begin
        if (q.size() == 0) check("unexpected_write", 1, 0);
        else begin
          e = q.pop_front();
          check("pixel_data", fifo_data, e.data);
          check("pixel_cycle", cyc, e.due);
        end
        last_data = fifo_data;
        have_last = 1'b1;
      end else if (have_last) begin
        check("data_hold", fifo_data, last_data);
      end
      if (frame_done) begin
        done_cnt++;
        last_err = frame_err;
      end else begin
        check("frame_err_idle", frame_err, 0);
      end
    end
  end

  task automatic drive(input bit v, input bit h, input logic [7:0] b);
    @(negedge clk);
    vs = v; hr = h; d = b;
    full = pend_full;
    pend_full = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    have_last = 1'b0;
    pend_full = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive_frame(input int l0, input int l1, input int nl, input logic [15:0] mask,
                             input int en_at, input int dis_at, input int rst_at);
    int bi = 0;
    int gp = 0;
    int nb;
    bit skip;
    logic [7:0] b = '0;
    logic [7:0] hi = '0;
    repeat (3) drive(1'b1, 1'b0, 8'h00);
    repeat (2) drive(1'b0, 1'b0, 8'h00);
    for (int ln = 0; ln < nl; ln++) begin
      nb = (ln == 0) ? l0 : l1;
      for (int i = 0; i < nb; i++) begin
        b = b + 8'd1;
        drive(1'b0, 1'b1, b);
        if (bi == en_at) enable = 1'b1;
        if (bi == dis_at) enable = 1'b0;
        if (i % 2 == 0) hi = b;
        else begin
          skip = DECIM && (((i / 2) % 2) == 1 || (ln % 2) == 1);
          if (!skip) begin
            if (mask[gp]) pend_full = 1'b1;
            else if (model_on) q.push_back('{data: {hi, b}, due: cyc + 2});
          end
          gp++;
        end
        if (bi == rst_at) begin
          @(posedge clk);
          #2;
          rst_n = 1'b0;
          model_on = 1'b0;
          have_last = 1'b0;
          #1;
          check("reset_outputs", int'({fifo_write, fifo_data, busy, frame_done, frame_err, overflow, ovf_count}), 0);
          #1;
          rst_n = 1'b1;
        end
        bi++;
      end
      repeat (3) drive(1'b0, 1'b0, 8'h00);
    end
    repeat (4) drive(1'b1, 1'b0, 8'h00);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[6];
    int   d0;
    int   eo;
    vecs[0] = '{"nominal",   8, 8, 2, 16'h0000, 1'b0, 0, 0};
    vecs[1] = '{"full_pix2", 8, 8, 2, 16'h0004, 1'b0, 1, 1};
    vecs[2] = '{"ovf_sat",   8, 8, 2, 16'h001F, 1'b0, 3, 2};
    vecs[3] = '{"odd_line",  9, 8, 2, 16'h0000, 1'b1, 0, 0};
    vecs[4] = '{"extra_ln",  8, 8, 3, 16'h0000, 1'b1, 0, 0};
    vecs[5] = '{"short_ln",  6, 8, 2, 16'h0000, 1'b1, 0, 0};

    do_reset();
    #1;
    check("reset_state", int'({fifo_write, fifo_data, busy, frame_done, frame_err, overflow, ovf_count}), 0);

    foreach (vecs[k]) begin
      do_reset();
      enable = 1'b1;
      model_on = 1'b1;
      d0 = done_cnt;
      drive_frame(vecs[k].l0, vecs[k].l1, vecs[k].nl, vecs[k].mask, -1, -1, -1);
      eo = DECIM ? vecs[k].ovf_dec : vecs[k].ovf;
      check({vecs[k].name, "_done"}, done_cnt - d0, 1);
      check({vecs[k].name, "_err"}, last_err, vecs[k].err);
      check({vecs[k].name, "_ovf_count"}, ovf_count, eo);
      check({vecs[k].name, "_overflow"}, overflow, (eo != 0) ? 1 : 0);
      check({vecs[k].name, "_missing"}, q.size(), 0);
      check({vecs[k].name, "_busy"}, busy, 1);
    end

    // enable raised mid-frame: that frame is skipped; next one captured while enable drops mid-frame
    do_reset();
    enable = 1'b0;
    model_on = 1'b0;
    d0 = done_cnt;
    drive_frame(8, 8, 2, 16'h0000, 3, -1, -1);
    check("midframe_no_done", done_cnt - d0, 0);
    check("midframe_busy", busy, 1);
    model_on = 1'b1;
    d0 = done_cnt;
    drive_frame(8, 8, 2, 16'h0000, -1, 5, -1);
    check("disable_done", done_cnt - d0, 1);
    check("disable_err", last_err, 0);
    check("disable_idle_busy", busy, 0);
    check("disable_missing", q.size(), 0);

    // reset right after the first byte of a pixel, then a clean frame
    do_reset();
    enable = 1'b1;
    model_on = 1'b1;
    d0 = done_cnt;
    drive_frame(8, 8, 2, 16'h0000, -1, -1, 0);
    check("rst_no_done", done_cnt - d0, 0);
    model_on = 1'b1;
    d0 = done_cnt;
    drive_frame(8, 8, 2, 16'h0000, -1, -1, -1);
    check("rst_next_done", done_cnt - d0, 1);
    check("rst_next_err", last_err, 0);
    check("rst_next_missing", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ov7670_capture_writer.md
Name: ov7670_capture_writer

Overview:
- Producer end of the camera pixel FIFO, running in the OV7670 PCLK domain (clk_write).
- Samples the camera parallel bus (vsync/href/d[7:0]) and pairs bytes into 16-bit RGB565 pixels.
- Drives the FIFO write port (write/data_write/full) and reports per-frame status.
- The read-side display/VGA logic drains the FIFO in its own clock domain.

Parameters:
- H_PIXELS, 640, expected pixels (byte pairs) per href line.
- V_LINES, 480, expected href lines per frame.
- OVF_CNT_WIDTH, 16, width of the saturating dropped-pixel counter.

Ports:
- clk_write  in  1  camera PCLK; all logic on posedge.
- rst_n  in  1  async active-low reset.
- enable  in  1  level; capture frames while high.
- cam_vsync  in  1  camera VSYNC, active-high frame blanking.
- cam_href  in  1  camera HREF, high during valid line bytes.
- cam_data  in  8  camera pixel byte.
- fifo_full  in  1  FIFO full flag, write-domain synchronous.
- fifo_write  out  1  one-cycle write strobe to the FIFO.
- fifo_data  out  16  pixel {first_byte, second_byte}.
- busy  out  1  high when state != IDLE.
- frame_done  out  1  one-cycle pulse at end of a captured frame.
- frame_err  out  1  valid with frame_done: geometry mismatch in the completed frame.
- overflow  out  1  sticky: a pixel was dropped because fifo_full was high; cleared on the IDLE->SYNC transition.
- ovf_count  out  OVF_CNT_WIDTH  saturating count of dropped pixels; cleared with overflow.

Behaviour:
- Reset is async and active-low on rst_n; clock is clk_write.
- Reset values: all outputs 0, state IDLE, phase 0, all counters 0.
- Input stage: cam_vsync/href/data are registered once (_q). Edge detection compares _q against the previous _q.
- FSM:
  - IDLE: enable=1 -> SYNC.
  - SYNC: vsync_q falling edge -> ACTIVE; pix_cnt, line_cnt and the frame error bit are cleared. If enabled mid-frame, the partial frame is skipped.
  - ACTIVE: vsync_q rising edge -> frame_done=1 for one cycle with frame_err. Next state is SYNC if enable=1, else IDLE.
  - enable is ignored while in ACTIVE; the current frame always completes.
- Byte pairing happens in ACTIVE while href_q=1:
  - phase 0: latch the byte as hi; phase<=1.
  - phase 1: form {hi, data_q}; phase<=0; pix_cnt++.
  - href_q=0 forces phase<=0.
- Write latency: fifo_write/fifo_data are registered. The strobe is high in the cycle after the edge at which the phase-1 byte was in data_q, i.e. 2 clk_write edges after the camera byte is present. The strobe lasts exactly one cycle, and fifo_data holds its value between writes.
- FIFO full: fifo_full is checked at the same edge as pixel completion. If full=1, fifo_write stays 0, the pixel is dropped, overflow<=1, and ovf_count increments, saturating at all-ones.
- href_q falling edge in ACTIVE:
  - line_cnt++.
  - pix_cnt != H_PIXELS or phase=1 (odd byte, which is discarded) sets the frame error bit.
  - pix_cnt<=0.
- At frame end: line_cnt != V_LINES sets the frame error bit. frame_err is driven only in the frame_done cycle and is 0 otherwise.
- Counters: pix_cnt and line_cnt are wide enough for 2*H_PIXELS and 2*V_LINES and saturate, never wrapping.
- Reset mid-frame: immediate return to IDLE. No write strobe is produced for a partially formed pixel.
- vsync rising while href=1 is treated as line end and frame end in the same cycle: line_cnt is incremented before the compare.

Optional Feature:
- Macro CAPTURE_DECIM_EN.
- Defined: 2:1 decimation in both axes. Only pixels with even pix_cnt on lines with even line_cnt are written, and dropped-by-decimation pixels do not touch overflow. Geometry checks still use raw H_PIXELS/V_LINES.
- Undefined: every pixel is written, and no decimation logic is synthesized.

Test Plan:
- Nominal frame, H_PIXELS=4, V_LINES=2, bytes 0x01..0x10, fifo_full=0 -> 8 writes.
  - fifo_data sequence 0x0102, 0x0304, ... 0x0F10.
  - frame_done pulse with frame_err=0.
  - Each strobe occurs 2 edges after its second byte.
- fifo_full=1 during the 3rd pixel -> that pixel is not written, overflow=1, ovf_count=1. Remaining pixels are written. Saturation check: OVF_CNT_WIDTH=2 with 5 drops -> ovf_count=3.
- Line with 9 bytes (odd) -> 4 writes on that line, 9th byte discarded, frame_err=1 at frame_done.
- enable raised mid-frame -> no writes until the next vsync falling edge. Then a full frame is captured. enable dropped in ACTIVE -> frame completes, then IDLE with busy=0.
- rst_n asserted after the first byte of a pixel -> all outputs 0 immediately. No write after release until the next SYNC -> ACTIVE.
- With CAPTURE_DECIM_EN, the 4x2 frame -> only line 0 pixels 0 and 2 are written (0x0102, 0x0506), frame_err=0.
